// File: rtl/frame_builder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frame_builder
// Description : Byte-stream framer feeding the modulator. Emits preamble,
//               sync word, 16-bit length, payload and CRC-16/CCITT-FALSE.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_builder #(
    parameter int unsigned PREAMBLE_LEN  = 4,
    parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
    parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D,
    parameter logic [15:0] CRC_INIT      = 16'hFFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_length,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_PREAMBLE = 3'd1;
    localparam logic [2:0] c_SYNC     = 3'd2;
    localparam logic [2:0] c_LENGTH   = 3'd3;
    localparam logic [2:0] c_PAYLOAD  = 3'd4;
    localparam logic [2:0] c_CRC      = 3'd5;

    localparam logic [15:0] c_PRE_LAST = 16'(PREAMBLE_LEN - 1);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_len;
    logic [15:0] r_crc;
    logic        w_load_en;
    logic [7:0]  w_sync_byte;

    // One CRC-16 (poly 0x1021) step over a whole byte, MSB first.
    function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {d, 8'h00};
        for (int b = 0; b < 8; b++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    assign w_load_en = !o_valid || i_ready;
    assign o_ready   = (r_state == c_PAYLOAD) && w_load_en;

    always_comb begin
        w_sync_byte = SYNC_WORD[31:24];
        case (r_cnt[1:0])
            2'd0:    w_sync_byte = SYNC_WORD[31:24];
            2'd1:    w_sync_byte = SYNC_WORD[23:16];
            2'd2:    w_sync_byte = SYNC_WORD[15:8];
            default: w_sync_byte = SYNC_WORD[7:0];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 16'd0;
            r_len   <= 16'd0;
            r_crc   <= CRC_INIT;
            o_data  <= 8'd0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (i_start) begin
                        r_len   <= i_length;
                        r_cnt   <= 16'd0;
                        r_crc   <= CRC_INIT;
                        o_busy  <= 1'b1;
                        r_state <= c_PREAMBLE;
                    end
                end
                c_PREAMBLE: begin
                    if (w_load_en) begin
                        o_data  <= PREAMBLE_BYTE;
                        o_valid <= 1'b1;
                        if (r_cnt == c_PRE_LAST) begin
                            r_cnt   <= 16'd0;
                            r_state <= c_SYNC;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                c_SYNC: begin
                    if (w_load_en) begin
                        o_data  <= w_sync_byte;
                        o_valid <= 1'b1;
                        if (r_cnt == 16'd3) begin
                            r_cnt   <= 16'd0;
                            r_state <= c_LENGTH;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                c_LENGTH: begin
                    if (w_load_en) begin
                        o_valid <= 1'b1;
                        if (r_cnt == 16'd0) begin
                            o_data <= r_len[15:8];
                            r_cnt  <= 16'd1;
                        end else begin
                            o_data  <= r_len[7:0];
                            r_cnt   <= 16'd0;
                            r_state <= (r_len == 16'd0) ? c_CRC : c_PAYLOAD;
                        end
                    end
                end
                c_PAYLOAD: begin
                    // A missing input byte lets the current output drain, leaving a gap.
                    if (w_load_en) begin
                        if (i_valid) begin
                            o_data  <= i_data;
                            o_valid <= 1'b1;
                            r_crc   <= f_crc_byte(r_crc, i_data);
                            if (r_cnt == r_len - 16'd1) begin
                                r_cnt   <= 16'd0;
                                r_state <= c_CRC;
                            end else begin
                                r_cnt <= r_cnt + 16'd1;
                            end
                        end else begin
                            o_valid <= 1'b0;
                        end
                    end
                end
                c_CRC: begin
                    if (w_load_en) begin
                        case (r_cnt[1:0])
                            2'd0: begin
                                o_data  <= r_crc[15:8];
                                o_valid <= 1'b1;
                                r_cnt   <= 16'd1;
                            end
                            2'd1: begin
                                o_data  <= r_crc[7:0];
                                o_valid <= 1'b1;
                                r_cnt   <= 16'd2;
                            end
                            default: begin
                                // Both CRC bytes loaded; load_en here means the last one just left.
                                o_valid <= 1'b0;
                                o_busy  <= 1'b0;
                                o_done  <= 1'b1;
                                r_cnt   <= 16'd0;
                                r_state <= c_IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_builder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_frame_builder
// Description : Self-checking bench for frame_builder with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_builder;

    localparam int          c_PRE_LEN = 4;
    localparam int          c_HDR_LEN = c_PRE_LEN + 6;
    localparam logic [31:0] c_SYNC    = 32'h1ACFFC1D;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_length = 16'd0;
    logic [7:0]  i_data = 8'd0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_busy;
    logic        o_done;

    always #5 clk = ~clk;

    frame_builder dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_length (i_length),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] pay[$];
    logic [7:0] exp_q[$];
    logic [7:0] out_q[$];
    logic [7:0] acc_q[$];
    int  done_cnt, stall_bad, ready_bad, busy_bad, first_x, last_x;
    bit  timed_out, post_done, post_busy, aborted;

    // Reference frame: header, payload, then CRC computed one message bit at a time.
    function automatic void build_exp(input int n);
        logic [15:0] crc;
        logic [7:0]  d;
        logic        fb;
        exp_q.delete();
        for (int k = 0; k < c_PRE_LEN; k++) exp_q.push_back(8'h55);
        for (int k = 3; k >= 0; k--) exp_q.push_back(8'(c_SYNC >> (8 * k)));
        exp_q.push_back(8'(n >> 8));
        exp_q.push_back(8'(n));
        crc = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            d = pay[i];
            exp_q.push_back(d);
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[15] ^ d[b];
                crc = {crc[14:0], 1'b0};
                if (fb) crc = crc ^ 16'h1021;
            end
        end
        exp_q.push_back(crc[15:8]);
        exp_q.push_back(crc[7:0]);
    endfunction

    function automatic int frame_diff();
        int lim;
        lim = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int k = 0; k < lim; k++) if (out_q[k] !== exp_q[k]) return k;
        if (out_q.size() != exp_q.size()) return lim;
        return -1;
    endfunction

    function automatic int acc_diff();
        int lim;
        lim = (acc_q.size() < pay.size()) ? acc_q.size() : pay.size();
        for (int k = 0; k < lim; k++) if (acc_q[k] !== pay[k]) return k;
        if (acc_q.size() != pay.size()) return lim;
        return -1;
    endfunction

    function automatic void seq_payload();
        pay.delete();
        for (int k = 0; k < 9; k++) pay.push_back(8'h31 + 8'(k));
    endfunction

    function automatic void rand_payload(input int n);
        pay.delete();
        for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
    endfunction

    // Drives one frame (start, payload source, modulator ready) and records the output stream.
    // rmode: 0 ready always, 1 one-on/two-off, 2 random. vmode: 0 valid always, 1 every 5th, 2 random.
    task automatic run_frame(input int n, input int rmode, input int vmode, input bit restart_mid,
                             input bit chain_next, input int chain_len, input int abort_at,
                             input bit pre_started);
        int         cyc, idx;
        bit         prev_stall, seen_done, vb;
        logic [7:0] prev_data;
        out_q.delete(); acc_q.delete();
        done_cnt = 0; stall_bad = 0; ready_bad = 0; busy_bad = 0; first_x = -1; last_x = -1;
        timed_out = 0; post_done = 0; post_busy = 0; aborted = 0;
        cyc = 0; idx = 0; prev_stall = 0; prev_data = 8'd0; seen_done = 0;
        if (!pre_started) begin
            @(posedge clk); #1;
            i_start = 1'b1; i_length = 16'(n);
        end
        while (1) begin
            @(posedge clk); #1;
            i_start = restart_mid && (cyc == 6 || cyc == 14);
            if (i_start) i_length = 16'd3;
            case (rmode)
                0:       i_ready = 1'b1;
                1:       i_ready = (cyc % 3 == 0);
                default: i_ready = ($urandom_range(0, 3) != 0);
            endcase
            case (vmode)
                0:       vb = 1'b1;
                1:       vb = (cyc % 5 == 0);
                default: vb = ($urandom_range(0, 2) != 0);
            endcase
            i_valid = vb && (idx < n);
            i_data  = (idx < n) ? pay[idx] : 8'($urandom);
            @(negedge clk);
            if (seen_done) begin
                post_done = o_done; post_busy = o_busy;
                break;
            end
            if (prev_stall && (!o_valid || o_data !== prev_data)) stall_bad++;
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            if (o_valid && i_ready) begin
                out_q.push_back(o_data);
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
            if (o_ready && (idx >= n || out_q.size() < c_HDR_LEN - 1)) ready_bad++;
            if (i_valid && o_ready) begin
                acc_q.push_back(i_data);
                idx++;
            end
            if (!o_busy && !o_done) busy_bad++;
            if (o_done) begin
                done_cnt++;
                seen_done = 1;
                if (chain_next) begin
                    i_start = 1'b1; i_length = 16'(chain_len);
                end
            end
            if (abort_at > 0 && idx == abort_at) begin
                i_reset = 1'b1;
                @(posedge clk); #1;
                i_reset = 1'b0; i_valid = 1'b0;
                aborted = 1;
                break;
            end
            cyc++;
            if (cyc > 3000) begin
                timed_out = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (o_data !== 8'd0) begin bad++; $display("FAIL reset_data: got %h want 00", o_data); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", o_ready); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        total++;
        if ({o_valid, o_busy, o_ready} !== 3'b000) begin
            bad++; $display("FAIL idle_after_reset: got valid/busy/ready=%b want 000", {o_valid, o_busy, o_ready});
        end
    endtask

    task automatic test_basic();
        int mi;
        logic [15:0] got_crc;
        seq_payload(); build_exp(9);
        run_frame(9, 0, 0, 0, 0, 0, 0, 0);
        total++; if (timed_out) begin bad++; $display("FAIL basic_timeout: got no o_done want o_done"); end
        mi = frame_diff();
        total++;
        if (mi >= 0) begin
            bad++; $display("FAIL basic_frame: diff at byte %0d, got %0d bytes want %0d", mi, out_q.size(), exp_q.size());
        end
        got_crc = (out_q.size() >= 2) ? {out_q[out_q.size()-2], out_q[out_q.size()-1]} : 16'hxxxx;
        total++; if (got_crc !== 16'h29B1) begin bad++; $display("FAIL basic_crc: got %h want 29b1", got_crc); end
        total++;
        if (last_x - first_x + 1 != 21) begin
            bad++; $display("FAIL basic_contiguous: got span %0d cycles want 21", last_x - first_x + 1);
        end
        total++; if (done_cnt != 1 || post_done) begin bad++; $display("FAIL basic_done_pulse: got %0d/%b want 1/0", done_cnt, post_done); end
        total++; if (post_busy || busy_bad != 0) begin bad++; $display("FAIL basic_busy: got post=%b lows=%0d want 0/0", post_busy, busy_bad); end
    endtask

    task automatic test_empty();
        int mi;
        pay.delete(); build_exp(0);
        run_frame(0, 0, 0, 0, 0, 0, 0, 0);
        mi = frame_diff();
        total++;
        if (mi >= 0 || timed_out) begin
            bad++; $display("FAIL empty_frame: diff at byte %0d, got %0d bytes want %0d", mi, out_q.size(), exp_q.size());
        end
        total++; if (ready_bad != 0) begin bad++; $display("FAIL empty_ready: got %0d o_ready cycles want 0", ready_bad); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL empty_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall();
        int mi;
        seq_payload(); build_exp(9);
        run_frame(9, 1, 0, 0, 0, 0, 0, 0);
        mi = frame_diff();
        total++;
        if (mi >= 0 || timed_out) begin
            bad++; $display("FAIL stall_frame: diff at byte %0d, got %0d bytes want %0d", mi, out_q.size(), exp_q.size());
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_hold: got %0d unstable stalls want 0", stall_bad); end
        mi = acc_diff();
        total++; if (mi >= 0) begin bad++; $display("FAIL stall_accept: diff at %0d, got %0d want %0d", mi, acc_q.size(), pay.size()); end
    endtask

    task automatic test_gaps();
        int mi;
        rand_payload(3); build_exp(3);
        run_frame(3, 0, 1, 0, 0, 0, 0, 0);
        mi = frame_diff();
        total++;
        if (mi >= 0 || timed_out) begin
            bad++; $display("FAIL gaps_frame: diff at byte %0d, got %0d bytes want %0d", mi, out_q.size(), exp_q.size());
        end
        mi = acc_diff();
        total++; if (mi >= 0) begin bad++; $display("FAIL gaps_accept: diff at %0d, got %0d want %0d", mi, acc_q.size(), pay.size()); end
        total++; if (ready_bad != 0) begin bad++; $display("FAIL gaps_ready: got %0d stray o_ready cycles want 0", ready_bad); end
    endtask

    task automatic test_back_to_back();
        int mi;
        seq_payload(); build_exp(9);
        run_frame(9, 0, 0, 1, 1, 5, 0, 0);
        mi = frame_diff();
        total++;
        if (mi >= 0 || timed_out) begin
            bad++; $display("FAIL restart_ignored: diff at byte %0d, got %0d bytes want %0d", mi, out_q.size(), exp_q.size());
        end
        total++; if (post_busy !== 1'b1) begin bad++; $display("FAIL chain_accept: got busy %b want 1", post_busy); end
        rand_payload(5); build_exp(5);
        run_frame(5, 0, 0, 0, 0, 0, 0, 1);
        mi = frame_diff();
        total++;
        if (mi >= 0 || timed_out) begin
            bad++; $display("FAIL chain_frame: diff at byte %0d, got %0d bytes want %0d", mi, out_q.size(), exp_q.size());
        end
        total++; if (first_x != 0) begin bad++; $display("FAIL chain_no_idle: got first byte at cycle %0d want 0", first_x); end
    endtask

    task automatic test_reset_mid();
        int mi;
        logic [15:0] got_crc;
        seq_payload();
        run_frame(9, 0, 0, 0, 0, 0, 5, 0);
        @(negedge clk);
        total++;
        if (!aborted || {o_data, o_valid, o_ready, o_busy, o_done} !== 12'd0) begin
            bad++; $display("FAIL mid_reset: got abort=%b data=%h v/r/b/d=%b want 1 00 0000",
                            aborted, o_data, {o_valid, o_ready, o_busy, o_done});
        end
        build_exp(9);
        run_frame(9, 0, 0, 0, 0, 0, 0, 0);
        mi = frame_diff();
        total++;
        if (mi >= 0 || timed_out) begin
            bad++; $display("FAIL post_reset_frame: diff at byte %0d, got %0d bytes want %0d", mi, out_q.size(), exp_q.size());
        end
        got_crc = (out_q.size() >= 2) ? {out_q[out_q.size()-2], out_q[out_q.size()-1]} : 16'hxxxx;
        total++; if (got_crc !== 16'h29B1) begin bad++; $display("FAIL post_reset_crc: got %h want 29b1", got_crc); end
    endtask

    task automatic test_random();
        int mi, n;
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(0, 24);
            rand_payload(n); build_exp(n);
            run_frame(n, 2, 2, 0, 0, 0, 0, 0);
            mi = frame_diff();
            total++;
            if (mi >= 0 || timed_out) begin
                bad++; $display("FAIL random_frame%0d: n=%0d diff at byte %0d, got %0d bytes want %0d",
                                f, n, mi, out_q.size(), exp_q.size());
            end
            total++;
            if (stall_bad != 0 || ready_bad != 0 || done_cnt != 1) begin
                bad++; $display("FAIL random_handshake%0d: got stall=%0d ready=%0d done=%0d want 0/0/1",
                                f, stall_bad, ready_bad, done_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_stall();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
